// File: rtl/uart_tx_prephiral.sv
// Memory-mapped UART transmitter: DATA writes feed a small FIFO that is serialised as 8N1 on tx.
// Build with UART_TX_PARITY_EN defined to append an even parity bit (8E1 frames).
module uart_tx_prephiral #(
    parameter int                             address_word_size = 16,
    parameter int                             data_word_size    = 8,
    parameter logic [address_word_size-1:0]   BASE_ADDR         = 16'h04,
    parameter int                             CLKS_PER_BIT      = 16,
    parameter int                             FIFO_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [address_word_size-1:0]  address_bus,
    input  logic [data_word_size-1:0]     data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [data_word_size-1:0]     data_out,
    output logic                          tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(data_word_size);
    localparam logic [address_word_size-1:0] STATUS_ADDR = BASE_ADDR + address_word_size'(1);
    localparam logic [PW:0]    FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]  LAST_BAUD = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0]  LAST_BIT  = NW'(data_word_size - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [data_word_size-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [PW:0]               count;
    logic                      full;
    logic                      empty;
    logic                      data_sel;
    logic                      status_sel;
    logic                      push;
    logic                      pop;
    logic                      ovf;
    logic                      ovf_set;
    logic [data_word_size-1:0] status;

    state_t                    state;
    state_t                    state_nxt;
    logic [BW-1:0]             baud;
    logic [NW-1:0]             bit_cnt;
    logic [data_word_size-1:0] shift;
    logic                      baud_end;
    logic                      bit_last;
    logic                      tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic                      parity;
`endif

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign data_sel   = wr_en && (address_bus == BASE_ADDR);
    assign status_sel = (address_bus == STATUS_ADDR);
    // Full is judged before the edge, so a same-cycle pop never rescues a write.
    assign push       = data_sel && !full;
    assign ovf_set    = data_sel && full;
    assign baud_end   = (baud == LAST_BAUD);
    assign bit_last   = (bit_cnt == LAST_BIT);

    always_comb begin
        status    = '0;
        status[0] = full;
        status[1] = empty;
        status[2] = (state != IDLE);
        status[3] = ovf;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow is sticky; a new overflow in the same cycle as a STATUS read wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            ovf      <= 1'b0;
        end else begin
            if (rd_en) begin
                data_out <= status_sel ? status : '0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (rd_en && status_sel) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (baud_end && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_nxt = parity;
                if (baud_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // tx is registered, so the line follows the state by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            tx <= tx_nxt;
            if (state == IDLE || baud_end) begin
                baud <= '0;
            end else begin
                baud <= baud + 1'b1;
            end
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (baud_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (pop) begin
                shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && baud_end) begin
                shift <= shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_prephiral.sv
// Scoreboard bench for uart_tx_prephiral: a timing-level FIFO/line model predicts frames and STATUS reads.
// Honours UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx_prephiral;

    localparam int          AW    = 16;
    localparam int          DW    = 8;
    localparam int          C     = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0004;
    localparam logic [15:0] STAT  = BASE + 16'd1;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
`else
    localparam int          NBITS = 10;
`endif
    localparam int          FC    = NBITS * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address_bus = '0;
    logic [7:0]  data_in = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  data_out;
    logic        tx;

    uart_tx_prephiral #(
        .address_word_size(AW),
        .data_word_size(DW),
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address_bus(address_bus),
        .data_in(data_in),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_out(data_out),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec  = 0;
    int errs = 0;
    bit armed = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         abort;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] rd_q[$];
    int         m_push[$];
    int         m_pop[$];
    int         tx_free = 0;
    bit         m_ovf = 1'b0;
    int         m_ovf_edge = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vec++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Bytes held in the FIFO just before edge e: pushed earlier, not yet popped.
    function automatic int occ_at(input int e);
        int n = 0;
        foreach (m_push[i]) if (m_push[i] < e && m_pop[i] >= e) n++;
        return n;
    endfunction

    // One bus cycle, driven after a falling edge and sampled on the next rising edge.
    task automatic bus_cycle(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] d);
        int e;
        int occ;
        int p;
        bit busy;
        bit ov;
        logic [7:0] st;
        e = cyc + 1;
        if (rd) begin
            if (a == STAT) begin
                occ  = occ_at(e);
                busy = 1'b0;
                foreach (m_pop[i]) if (m_pop[i] < e && e <= m_pop[i] + FC) busy = 1'b1;
                ov   = m_ovf && (m_ovf_edge < e);
                st   = {4'b0000, ov, busy, (occ == 0), (occ == DEPTH)};
                m_ovf = 1'b0;
            end else begin
                st = 8'h00;
            end
            rd_q.push_back(st);
        end
        if (wr && a == BASE) begin
            if (occ_at(e) >= DEPTH) begin
                m_ovf      = 1'b1;
                m_ovf_edge = e;
            end else begin
                p       = (e + 1 > tx_free) ? e + 1 : tx_free;
                tx_free = p + FC;
                m_push.push_back(e);
                m_pop.push_back(p);
                exp_q.push_back('{d, p + 1, 1'b0});
            end
        end
        address_bus = a;
        data_in     = d;
        wr_en       = wr;
        rd_en       = rd;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        int r;
        frame_t keep[$];
        frame_t f;
        rst = 1'b1;
        r   = cyc + 1;
        foreach (exp_q[i]) begin
            if (exp_q[i].start < r) begin
                f       = exp_q[i];
                f.abort = 1'b1;
                keep.push_back(f);
            end
        end
        exp_q = keep;
        m_push.delete();
        m_pop.delete();
        tx_free = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        check("tx_on_reset_edge", 64'(tx), 64'd1);
        repeat (n - 1) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout_frames_left", 64'(exp_q.size()), 64'd0);
    endtask

    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= rd_en;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_read: got %0h expected none", data_out);
            end else begin
                check("read_data", 64'(data_out), 64'(rd_q.pop_front()));
            end
        end
    end

    // Line receiver: captures one whole frame per falling start edge, clock by clock.
    initial begin : frame_mon
        logic [63:0]      line;
        logic [63:0]      expl;
        logic [NBITS-1:0] fb;
        int               s;
        bit               ab;
        frame_t           f;
        forever begin
            @(negedge clk);
            if (armed && !rst && tx === 1'b0) begin
                s    = cyc;
                ab   = 1'b0;
                line = '0;
                for (int j = 1; j < FC; j++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    line[j] = tx;
                end
                if (exp_q.size() == 0) begin
                    vec++;
                    errs++;
                    $display("FAIL unexpected_frame: got frame at cycle %0d expected none", s);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_aborted", 64'(ab), 64'(f.abort));
                    if (!ab && !f.abort) begin
`ifdef UART_TX_PARITY_EN
                        fb = {1'b1, ^f.data, f.data, 1'b0};
`else
                        fb = {1'b1, f.data, 1'b0};
`endif
                        expl = '0;
                        for (int j = 0; j < FC; j++) expl[j] = fb[j / C];
                        check("frame_start_cycle", 64'(s), 64'(f.start));
                        check("frame_line", line, expl);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         op;
        int         gap;
        logic [7:0] d;
        logic [15:0] a;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_data_out", 64'(data_out), 64'd0);

        // Single frame with start latency, then idle STATUS.
        bus_cycle(1'b1, 1'b0, BASE, 8'hA5);
        check("tx_high_after_write", 64'(tx), 64'd1);
        @(negedge clk);
        check("tx_high_before_start", 64'(tx), 64'd1);
        drain();
        bus_cycle(1'b0, 1'b1, STAT, 8'h00);
        check("idle_status", 64'(data_out), 64'h02);

        // Back-to-back frames, and parity-sensitive patterns.
        bus_cycle(1'b1, 1'b0, BASE, 8'h01);
        bus_cycle(1'b1, 1'b0, BASE, 8'h80);
        drain();
        bus_cycle(1'b1, 1'b0, BASE, 8'h07);
        bus_cycle(1'b1, 1'b0, BASE, 8'h03);
        drain();

        // Overflow: six consecutive writes, then two STATUS reads.
        for (int i = 0; i < 6; i++) bus_cycle(1'b1, 1'b0, BASE, 8'($urandom));
        bus_cycle(1'b0, 1'b1, STAT, 8'h00);
        check("overflow_status_bits", 64'(data_out & 8'h0D), 64'h0D);
        bus_cycle(1'b0, 1'b1, STAT, 8'h00);
        check("overflow_cleared", 64'(data_out[3]), 64'd0);
        drain();

        // Unmapped read/write, and writes to STATUS, must not produce frames.
        bus_cycle(1'b0, 1'b1, 16'h0002, 8'h00);
        bus_cycle(1'b1, 1'b0, 16'h0002, 8'h5A);
        bus_cycle(1'b1, 1'b0, STAT, 8'hC3);
        repeat (60) @(negedge clk);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 9);
            d   = 8'($urandom);
            gap = $urandom_range(0, (i % 3 == 0) ? 40 : 2);
            repeat (gap) @(negedge clk);
            case (op)
                0, 1, 2, 3, 4: bus_cycle(1'b1, 1'b0, BASE, d);
                5: begin
                    a = 16'($urandom_range(0, 15));
                    bus_cycle(1'b1, 1'b0, a, d);
                end
                6, 7: bus_cycle(1'b0, 1'b1, STAT, 8'h00);
                8: begin
                    a = 16'($urandom);
                    bus_cycle(1'b0, 1'b1, a, 8'h00);
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? STAT : BASE;
                    bus_cycle(1'b1, 1'b1, a, d);
                end
            endcase
        end
        drain();

        // Reset in the middle of the data bits of a 0x00 frame.
        bus_cycle(1'b1, 1'b0, BASE, 8'h00);
        repeat (3 * C + 2) @(negedge clk);
        check("tx_mid_data", 64'(tx), 64'd0);
        do_reset(1);
        bus_cycle(1'b0, 1'b1, STAT, 8'h00);
        repeat (100) @(negedge clk);
        check("no_frame_after_reset", 64'(exp_q.size()), 64'd0);
        check("reads_all_seen", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
